// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// Producer/consumer handshake bundle for mux_arb_n.
interface mux_arb_n_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_IN  = 3
) ();

  localparam int SEL_W = clog2(N_IN);

  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic                  force_sel_en;
  logic [SEL_W-1:0]      force_sel;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_src;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid,
    output force_sel_en, force_sel,
    output out_ready,
    input  in_ready,
    input  out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid,
    input  force_sel_en, force_sel,
    input  out_ready,
    output in_ready,
    output out_data, out_src, out_valid
  );

endinterface

// File: rtl/rr_arbiter_n.sv
// One-hot grant over N_IN requesters: fixed priority or
// round-robin with a pointer that advances past each winner.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter  int N_IN  = 3,
  parameter  int MODE  = MODE_FIXED,
  localparam int SEL_W = clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  i_elig,
  input  logic             i_advance,
  output logic [N_IN-1:0]  o_grant,
  output logic [SEL_W-1:0] o_idx
);

  if (MODE == MODE_RR) begin : g_rr
    logic [SEL_W-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_ptr <= '0;
      else if (i_advance)
        r_ptr <= (o_idx == SEL_W'(N_IN - 1)) ?
                 '0 : o_idx + SEL_W'(1);
    end

    // Search from the pointer upward, then wrap to the low channels.
    always_comb begin
      logic found;
      found   = 1'b0;
      o_grant = '0;
      o_idx   = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (!found && i_elig[i] && SEL_W'(i) >= r_ptr) begin
          found      = 1'b1;
          o_grant[i] = 1'b1;
          o_idx      = SEL_W'(i);
        end
      end
      for (int i = 0; i < N_IN; i++) begin
        if (!found && i_elig[i]) begin
          found      = 1'b1;
          o_grant[i] = 1'b1;
          o_idx      = SEL_W'(i);
        end
      end
    end
  end else begin : g_fix
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, i_advance};

    always_comb begin
      logic found;
      found   = 1'b0;
      o_grant = '0;
      o_idx   = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (!found && i_elig[i]) begin
          found      = 1'b1;
          o_grant[i] = 1'b1;
          o_idx      = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-input arbitrating mux with one registered output stage,
// valid/ready on every port and an optional forced select.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_IN  = 3,
  parameter int MODE  = MODE_FIXED
) (
  input logic        clk,
  input logic        rst,
  mux_arb_n_if.slave bus
);

  localparam int SEL_W = clog2(N_IN);

  logic [N_IN-1:0]  w_elig;
  logic [N_IN-1:0]  w_grant;
  logic [N_IN-1:0]  w_ready;
  logic [SEL_W-1:0] w_idx;
  logic             w_load_en;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_src;
  logic             r_valid;

  // An out-of-range forced index matches no channel.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_IN; i++)
      w_elig[i] = bus.in_valid[i] &
                  (!bus.force_sel_en |
                   (bus.force_sel == SEL_W'(i)));
  end

  rr_arbiter_n #(
    .N_IN (N_IN),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_elig    (w_elig),
    .i_advance (w_xfer),
    .o_grant   (w_grant),
    .o_idx     (w_idx)
  );

  assign w_load_en = !r_valid | bus.out_ready;
  assign w_ready   = rst ? '0 :
                     (w_grant & {N_IN{w_load_en}});
  assign w_xfer    = |(bus.in_valid & w_ready);

  // AND-OR select keeps unselected channels off out_data.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_IN; i++)
      w_data |= {WIDTH{w_grant[i]}} &
                bus.in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= w_data;
      r_src   <= w_idx;
      r_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench: fixed-priority and round-robin instances
// driven side by side from one linear stimulus sequence.
module tb_mux_arb_n;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mux_arb_n_if #(.WIDTH(16), .N_IN(3)) b0 ();
  mux_arb_n_if #(.WIDTH(16), .N_IN(3)) b1 ();

  mux_arb_n #(
    .WIDTH (16), .N_IN (3), .MODE (MODE_FIXED)
  ) u_fix (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );

  mux_arb_n #(
    .WIDTH (16), .N_IN (3), .MODE (MODE_RR)
  ) u_rr (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b0.in_data = '0; b0.in_valid = '0;
    b0.force_sel_en = 1'b0; b0.force_sel = '0;
    b0.out_ready = 1'b0;
    b1.in_data = '0; b1.in_valid = '0;
    b1.force_sel_en = 1'b0; b1.force_sel = '0;
    b1.out_ready = 1'b0;

    #12;
    chk("rst_val0", 32'(b0.out_valid), 0);
    chk("rst_dat0", 32'(b0.out_data), 0);
    chk("rst_src0", 32'(b0.out_src), 0);
    chk("rst_val1", 32'(b1.out_valid), 0);
    b0.in_valid = 3'b111; b1.in_valid = 3'b111;
    b0.out_ready = 1'b1; b1.out_ready = 1'b1;
    #1;
    chk("rst_rdy0", 32'(b0.in_ready), 0);
    chk("rst_rdy1", 32'(b1.in_ready), 0);
    b0.in_valid = '0; b1.in_valid = '0;
    rst = 1'b0;

    // fixed priority: channel 1 beats channel 2
    b0.in_data = {16'h2222, 16'h1111, 16'h0000};
    b0.in_valid = 3'b110;
    #1;
    chk("p_rdy", 32'(b0.in_ready), 'b010);
    tick();
    chk("p_dat", 32'(b0.out_data), 'h1111);
    chk("p_src", 32'(b0.out_src), 1);
    chk("p_val", 32'(b0.out_valid), 1);
    chk("p_rdy_hold", 32'(b0.in_ready), 'b010);
    b0.in_valid = 3'b100;
    #1;
    chk("p_rdy2", 32'(b0.in_ready), 'b100);
    tick();
    chk("p_dat2", 32'(b0.out_data), 'h2222);
    chk("p_src2", 32'(b0.out_src), 2);
    b0.in_valid = '0;
    tick();
    chk("p_drain", 32'(b0.out_valid), 0);
    chk("p_dhold", 32'(b0.out_data), 'h2222);

    // backpressure
    b0.in_data = {16'h2222, 16'h1111, 16'hAAAA};
    b0.in_valid = 3'b001;
    b0.out_ready = 1'b0;
    tick();
    chk("bp_load", 32'(b0.out_data), 'hAAAA);
    chk("bp_lval", 32'(b0.out_valid), 1);
    b0.in_data[15:0] = 16'hBBBB;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_dat", 32'(b0.out_data), 'hAAAA);
      chk("bp_rdy", 32'(b0.in_ready), 0);
      chk("bp_val", 32'(b0.out_valid), 1);
      tick();
    end
    b0.out_ready = 1'b1;
    #1;
    chk("bp_go_rdy", 32'(b0.in_ready), 'b001);
    tick();
    chk("bp_new", 32'(b0.out_data), 'hBBBB);
    chk("bp_nval", 32'(b0.out_valid), 1);
    chk("bp_nsrc", 32'(b0.out_src), 0);
    b0.in_valid = '0;
    tick();
    chk("bp_drain", 32'(b0.out_valid), 0);

    // forced select
    b0.force_sel_en = 1'b1;
    b0.force_sel = 2'd2;
    b0.in_data = {16'h2C2C, 16'h1C1C, 16'h0C0C};
    b0.in_valid = 3'b111;
    #1;
    chk("f_rdy", 32'(b0.in_ready), 'b100);
    tick();
    chk("f_dat", 32'(b0.out_data), 'h2C2C);
    chk("f_src", 32'(b0.out_src), 2);
    b0.force_sel = 2'd3;
    #1;
    chk("f_rdy_none", 32'(b0.in_ready), 0);
    chk("f_pend", 32'(b0.out_valid), 1);
    tick();
    chk("f_drain", 32'(b0.out_valid), 0);
    chk("f_dhold", 32'(b0.out_data), 'h2C2C);
    tick();
    chk("f_idle", 32'(b0.out_valid), 0);
    b0.force_sel_en = 1'b0;
    b0.in_valid = '0;

    // round-robin, all channels valid
    b1.in_data = {16'hA002, 16'hA001, 16'hA000};
    b1.in_valid = 3'b111;
    #1;
    chk("rr_rdy0", 32'(b1.in_ready), 'b001);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_src", 32'(b1.out_src), 32'(k % 3));
      chk("rr_dat", 32'(b1.out_data), 32'('hA000 + k % 3));
      chk("rr_val", 32'(b1.out_valid), 1);
    end

    // wrap after channel 2
    b1.in_valid = 3'b100;
    #1;
    chk("w_rdy", 32'(b1.in_ready), 'b100);
    tick();
    chk("w_src2", 32'(b1.out_src), 2);
    b1.in_valid = 3'b011;
    #1;
    chk("w_rdy2", 32'(b1.in_ready), 'b001);
    tick();
    chk("w_src0", 32'(b1.out_src), 0);
    chk("w_dat0", 32'(b1.out_data), 'hA000);

    // pointer holds through a stall
    b1.out_ready = 1'b0;
    b1.in_valid = 3'b111;
    #1;
    chk("st_rdy", 32'(b1.in_ready), 0);
    tick();
    tick();
    chk("st_src", 32'(b1.out_src), 0);
    chk("st_dat", 32'(b1.out_data), 'hA000);
    b1.out_ready = 1'b1;
    b1.in_valid = '0;
    tick();
    chk("st_drain", 32'(b1.out_valid), 0);
    b1.in_valid = 3'b101;
    #1;
    chk("st_ptr", 32'(b1.in_ready), 'b100);
    tick();
    chk("st_src2", 32'(b1.out_src), 2);
    b1.in_valid = 3'b001;
    tick();
    chk("st_src0", 32'(b1.out_src), 0);
    b1.in_valid = '0;

    // asynchronous reset mid-cycle
    b0.in_data = {16'h5555, 16'h0000, 16'h0000};
    b0.in_valid = 3'b100;
    b0.out_ready = 1'b1;
    tick();
    chk("ar_psrc", 32'(b0.out_src), 2);
    chk("ar_pval", 32'(b0.out_valid), 1);
    b0.in_valid = '0;
    b0.out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("ar_val", 32'(b0.out_valid), 0);
    chk("ar_dat", 32'(b0.out_data), 0);
    chk("ar_src", 32'(b0.out_src), 0);
    b0.in_valid = 3'b111;
    b1.in_valid = 3'b111;
    #1;
    chk("ar_rdy0", 32'(b0.in_ready), 0);
    chk("ar_rdy1", 32'(b1.in_ready), 0);
    tick();
    chk("ar_hold0", 32'(b0.out_valid), 0);
    chk("ar_hold1", 32'(b1.out_valid), 0);
    rst = 1'b0;
    b0.out_ready = 1'b1;
    #1;
    chk("ar_ptr", 32'(b1.in_ready), 'b001);
    chk("ar_fix", 32'(b0.in_ready), 'b001);
    tick();
    chk("ar_rsrc", 32'(b1.out_src), 0);
    chk("ar_rval", 32'(b1.out_valid), 1);
    b0.in_valid = '0;
    b1.in_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
